object_layer_arbiter: RTL and testbench

- Upstream neighbour of the colour mux. Each clock it takes per-object draw requests for the current pixel and selects the winning layer by fixed priority. It emits a registered object code 0..7 (BACKGROUND..GATEB) on object_to_draw.
- It also counts frog/object pixel overlaps across each frame. At frame end it publishes one collision verdict through a valid/ack handshake to the game controller.

---
 rtl/frog_game_pkg.sv | 39 +++
 rtl/layer_priority_enc.sv | 34 +++
 rtl/object_layer_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_object_layer_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/frog_game_pkg.sv
// ============================================================================
//  Module      : frog_game_pkg
//  Description : Shared object codes, collision verdicts and arbiter FSM
//                states for the frog game video pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package frog_game_pkg;

  // Object codes shared by the arbiter, colour mux and game controller
  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] WATERFALL  = 3'd1;
  localparam logic [2:0] LOG        = 3'd2;
  localparam logic [2:0] FROG       = 3'd3;
  localparam logic [2:0] ENDBANK    = 3'd4;
  localparam logic [2:0] FRENCH     = 3'd5;
  localparam logic [2:0] GATEA      = 3'd6;
  localparam logic [2:0] GATEB      = 3'd7;

  // Per-frame collision verdict reported to the game controller
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    RIDE  = 3'd1,
    DROWN = 3'd2,
    WIN   = 3'd3,
    HIT   = 3'd4
  } verdict_t;

  // Frame accumulation state machine
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/layer_priority_enc.sv
// ============================================================================
//  Module      : layer_priority_enc
//  Description : Fixed-priority encoder turning the per-object request mask
//                into the code of the topmost visible layer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_priority_enc
  import frog_game_pkg::*;
(
  input  logic [7:0] req,
  output logic [2:0] code
);

  // Background never competes; it is simply the fall-through result
  logic w_unused_bg;
  assign w_unused_bg = req[BACKGROUND];

  // Topmost layer wins: frog sits above the gates, which sit above scenery
  always_comb begin
    code = BACKGROUND;
    if      (req[FROG])      code = FROG;
    else if (req[GATEA])     code = GATEA;
    else if (req[GATEB])     code = GATEB;
    else if (req[FRENCH])    code = FRENCH;
    else if (req[LOG])       code = LOG;
    else if (req[ENDBANK])   code = ENDBANK;
    else if (req[WATERFALL]) code = WATERFALL;
  end

endmodule

`default_nettype wire

// File: rtl/object_layer_arbiter.sv
// ============================================================================
//  Module      : object_layer_arbiter
//  Description : Selects the winning draw layer per pixel and accumulates
//                frog overlap counts across a frame, publishing one
//                collision verdict per frame over a valid/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module object_layer_arbiter
  import frog_game_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int RIDE_THRESH  = 16,
  parameter int DROWN_THRESH = 8,
  parameter int WIN_THRESH   = 32,
  parameter int HIT_THRESH   = 1
)(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       start_of_frame,
  input  logic       pixel_valid,
  input  logic [7:0] draw_req,
  output logic [7:0] object_to_draw,
  output logic [2:0] verdict,
  output logic       verdict_valid,
  input  logic       verdict_ack,
  output logic       overrun
);

  // Next value of a saturating overlap counter, optionally restarting from 0
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             clr,
                                                input logic             inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != {CNT_W{1'b1}}))
      cnt_next = base + CNT_W'(1);
    else
      cnt_next = base;
  endfunction

  logic [2:0]       w_code;
  logic [7:0]       r_obj;
  fsm_state_t       r_state;
  fsm_state_t       w_state_nxt;
  logic             w_close;
  logic             w_publish;
  logic             w_restart;
  logic             w_count_en;
  logic [CNT_W-1:0] r_ride_cnt;
  logic [CNT_W-1:0] r_drown_cnt;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  verdict_t         w_frame_verdict;
  verdict_t         r_pend_verdict;
  verdict_t         r_verdict;
  logic             r_valid;
  logic             r_overrun;

  layer_priority_enc u_enc (
    .req  (draw_req),
    .code (w_code)
  );

  // Registered layer code; blank pixels always show background
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      r_obj <= 8'd0;
    else if (pixel_valid)
      r_obj <= {5'd0, w_code};
    else
      r_obj <= {5'd0, BACKGROUND};
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state: every start_of_frame after arming closes a frame and
  // schedules a one-cycle REPORT; back-to-back pulses keep re-entering it
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_of_frame) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (start_of_frame) begin
          w_close     = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        w_publish = 1'b1;
        if (start_of_frame) begin
          w_close     = 1'b1;
          w_state_nxt = REPORT;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The frame-start pixel belongs to the new frame, so counters restart and
  // include it in the same cycle; REPORT cycles keep counting so none is lost
  assign w_restart  = start_of_frame | (r_state == IDLE);
  assign w_count_en = pixel_valid & draw_req[FROG] &
                      ((r_state != IDLE) | start_of_frame);

  // Saturating overlap counters
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ride_cnt  <= '0;
      r_drown_cnt <= '0;
      r_win_cnt   <= '0;
      r_hit_cnt   <= '0;
    end else begin
      r_ride_cnt  <= cnt_next(r_ride_cnt,  w_restart, w_count_en & draw_req[LOG]);
      r_drown_cnt <= cnt_next(r_drown_cnt, w_restart,
                              w_count_en & draw_req[WATERFALL] & ~draw_req[LOG]);
      r_win_cnt   <= cnt_next(r_win_cnt,   w_restart, w_count_en & draw_req[ENDBANK]);
      r_hit_cnt   <= cnt_next(r_hit_cnt,   w_restart,
                              w_count_en & (draw_req[FRENCH] | draw_req[GATEA] |
                                            draw_req[GATEB]));
    end
  end

  // Verdict of the frame being closed, from the counts before this pixel
  always_comb begin
    w_frame_verdict = NONE;
    if (r_win_cnt >= CNT_W'(WIN_THRESH))
      w_frame_verdict = WIN;
    else if (r_hit_cnt >= CNT_W'(HIT_THRESH))
      w_frame_verdict = HIT;
    else if (r_drown_cnt >= CNT_W'(DROWN_THRESH))
      w_frame_verdict = DROWN;
    else if (r_ride_cnt >= CNT_W'(RIDE_THRESH))
      w_frame_verdict = RIDE;
  end

  // Hold the closed frame's verdict for the following REPORT cycle
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      r_pend_verdict <= NONE;
    else if (w_close)
      r_pend_verdict <= w_frame_verdict;
  end

  // Publish/ack handshake; a publish always wins over a same-cycle ack
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_verdict <= NONE;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_publish) begin
      r_verdict <= r_pend_verdict;
      r_valid   <= 1'b1;
      if (r_valid && !verdict_ack)
        r_overrun <= 1'b1;
    end else if (r_valid && verdict_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign object_to_draw = r_obj;
  assign verdict        = r_verdict;
  assign verdict_valid  = r_valid;
  assign overrun        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_object_layer_arbiter.sv
// ============================================================================
//  Module      : tb_object_layer_arbiter
//  Description : Self-checking bench for object_layer_arbiter (layer
//                priority, frame verdicts, handshake, overrun, reset).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_object_layer_arbiter;
  import frog_game_pkg::*;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       start_of_frame = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] draw_req = 8'd0;
  logic       verdict_ack = 1'b0;
  logic [7:0] object_to_draw;
  logic [2:0] verdict;
  logic       verdict_valid;
  logic       overrun;

  object_layer_arbiter dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .start_of_frame (start_of_frame),
    .pixel_valid    (pixel_valid),
    .draw_req       (draw_req),
    .object_to_draw (object_to_draw),
    .verdict        (verdict),
    .verdict_valid  (verdict_valid),
    .verdict_ack    (verdict_ack),
    .overrun        (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [2:0] v;
    logic       ovr;
  } vexp_t;

  vexp_t      q_verd[$];
  logic [7:0] q_pix[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       exp_ovr = 1'b0;
  logic       prev_valid = 1'b0;
  logic       auto_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference layer choice: walk the ranking low to high, last hit wins
  function automatic logic [7:0] exp_code(input logic pv, input logic [7:0] req);
    int order[7];
    order = '{1, 4, 2, 5, 7, 6, 3};
    exp_code = 8'd0;
    if (pv)
      for (int i = 0; i < 7; i++)
        if (req[order[i]]) exp_code = 8'(order[i]);
  endfunction

  // One clock of stimulus followed by all per-cycle scoreboard checks
  task automatic step(input logic sof, input logic pv, input logic [7:0] req);
    logic  due_hit;
    vexp_t e;
    @(negedge CLK);
    start_of_frame = sof;
    pixel_valid    = pv;
    draw_req       = req;
    verdict_ack    = auto_ack;
    q_pix.push_back(exp_code(pv, req));
    @(posedge CLK);
    cyc++;
    #1;
    chk("pixel", object_to_draw, q_pix.pop_front());
    due_hit = 1'b0;
    if (q_verd.size() > 0 && q_verd[0].due == cyc) begin
      e = q_verd.pop_front();
      due_hit = 1'b1;
      chk("verdict_valid", verdict_valid, 1);
      chk("verdict", verdict, e.v);
      exp_ovr = e.ovr;
    end
    if (!prev_valid) chk("valid_rise", verdict_valid, due_hit);
    chk("overrun", overrun, exp_ovr);
    prev_valid = verdict_valid;
  endtask

  // Close the current frame with a start_of_frame and expect its verdict
  task automatic sof_close(input logic [2:0] v, input logic ovr);
    vexp_t e;
    e.due = cyc + 2;
    e.v   = v;
    e.ovr = ovr;
    q_verd.push_back(e);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame_pixels(input int n, input logic [7:0] req);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, req);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_obj", object_to_draw, 0);
    chk("rst_verdict", verdict, NONE);
    chk("rst_valid", verdict_valid, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;

    // Layer priority in IDLE
    step(1'b0, 1'b1, 8'b0000_0110);
    step(1'b0, 1'b1, 8'b1100_1000);
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b1, 8'h12);
    for (int i = 0; i < 30; i++)
      step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));

    // Ride frame, then verdict held with no ack
    step(1'b1, 1'b1, 8'h00);
    frame_pixels(20, 8'h0C);
    sof_close(RIDE, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("hold_verdict", verdict, RIDE);
      chk("hold_valid", verdict_valid, 1);
    end
    auto_ack = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    chk("ack_clear", verdict_valid, 0);

    // Empty frame, drown beats ride, 7 uncovered pixels falls back to ride
    sof_close(NONE, 1'b0);
    frame_pixels(8, 8'h0A);
    frame_pixels(30, 8'h0E);
    sof_close(DROWN, 1'b0);
    frame_pixels(7, 8'h0A);
    frame_pixels(30, 8'h0E);
    sof_close(RIDE, 1'b0);

    // Win outranks hit
    frame_pixels(40, 8'h18);
    frame_pixels(5, 8'h28);
    sof_close(WIN, 1'b0);

    // Single gate pixel gives hit; back-to-back pulse closes an empty frame
    // while the ack lands on the second publish
    frame_pixels(3, 8'h0C);
    frame_pixels(1, 8'h48);
    sof_close(HIT, 1'b0);
    sof_close(NONE, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("b2b_acked", verdict_valid, 0);

    // Overrun: unacked verdict overwritten by the next one
    auto_ack = 1'b0;
    frame_pixels(20, 8'h0C);
    sof_close(RIDE, 1'b0);
    frame_pixels(4, 8'h00);
    frame_pixels(1, 8'h28);
    sof_close(HIT, 1'b1);
    frame_pixels(3, 8'h00);
    // Third publish coincides with an ack
    sof_close(NONE, 1'b1);
    auto_ack = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    chk("ack_on_publish_valid", verdict_valid, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("ack_after_publish", verdict_valid, 0);
    auto_ack = 1'b0;

    // Reset mid-frame
    frame_pixels(10, 8'h0C);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    chk("mid_rst_obj", object_to_draw, 0);
    chk("mid_rst_verdict", verdict, NONE);
    chk("mid_rst_valid", verdict_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    q_verd.delete();
    exp_ovr    = 1'b0;
    prev_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("armed_no_verdict", verdict_valid, 0);
    end
    sof_close(NONE, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_valid", verdict_valid, 1);
    chk("post_rst_verdict", verdict, NONE);
    chk("queue_drained", q_verd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
